// File: rtl/pwm_duty_ramp_if.sv
// Signal bundle between the duty-ramp controller and its driver:
// control inputs (en/target/fault) and the duty word and status it returns.
interface pwm_duty_ramp_if #(
  parameter int unsigned DUTY_W = 4
);
  logic              en;
  logic [DUTY_W-1:0] target;
  logic              fault;
  logic              fault_clr;
  logic [DUTY_W-1:0] duty;
  logic              period_tick;
  logic              at_target;
  logic [1:0]        state;

  modport master (
    output en, target, fault, fault_clr,
    input  duty, period_tick, at_target, state
  );

  modport slave (
    input  en, target, fault, fault_clr,
    output duty, period_tick, at_target, state
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Slew-limited duty controller for the PWM: duty moves one step per STEP_DIV
// periods, only on period boundaries, with an immediate fault shutdown.
module pwm_duty_ramp #(
  parameter int unsigned DUTY_W   = 4,
  parameter int unsigned DUTY_MAX = 8,
  parameter int unsigned PERIOD   = 8,
  parameter int unsigned STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  pwm_duty_ramp_if.slave bus
);

  localparam int unsigned PCNT_W = (PERIOD   > 1) ? $clog2(PERIOD)   : 1;
  localparam int unsigned SDIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 1);
  localparam logic [SDIV_W-1:0] SDIV_LAST = SDIV_W'(STEP_DIV - 1);
  localparam logic [DUTY_W-1:0] DMAX      = DUTY_W'(DUTY_MAX);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RAMP  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic [PCNT_W-1:0] pcnt;
  logic [SDIV_W-1:0] sdiv;
  logic [DUTY_W-1:0] duty_q;
  logic [1:0]        state_q;
  logic              tick;
  logic [DUTY_W-1:0] tgt_c;
  logic [DUTY_W-1:0] eff_tgt;
  logic [DUTY_W-1:0] duty_step;

  assign tick = (pcnt == PCNT_LAST);

  always_comb begin
    tgt_c   = (bus.target > DMAX) ? DMAX : bus.target;
    eff_tgt = bus.en ? tgt_c : '0;
    duty_step = duty_q;
    if (duty_q < eff_tgt) begin
      duty_step = duty_q + DUTY_W'(1);
    end else if (duty_q > eff_tgt) begin
      duty_step = duty_q - DUTY_W'(1);
    end
  end

  // Period counter runs in every state so it stays phase-locked to the PWM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      sdiv    <= '0;
    end else if (bus.fault) begin
      state_q <= ST_FAULT;
      duty_q  <= '0;
      sdiv    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_q <= '0;
          sdiv   <= '0;
          if (bus.en) begin
            state_q <= ST_RAMP;
          end
        end
        ST_RAMP: begin
          // Exits are checked before stepping so a boundary never overshoots.
          if (bus.en && (duty_q == eff_tgt)) begin
            state_q <= ST_HOLD;
          end else if (!bus.en && (duty_q == '0)) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            if (sdiv == SDIV_LAST) begin
              sdiv   <= '0;
              duty_q <= duty_step;
            end else begin
              sdiv <= sdiv + SDIV_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (duty_q != eff_tgt) begin
            state_q <= ST_RAMP;
            sdiv    <= '0;
          end else if (!bus.en && (duty_q == '0)) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          duty_q <= '0;
          sdiv   <= '0;
          if (bus.fault_clr) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.duty        = duty_q;
  assign bus.period_tick = tick;
  assign bus.at_target   = (state_q == ST_HOLD);
  assign bus.state       = state_q;

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
Upstream stage of the PWM generator. It turns a raw duty request into a slew-limited duty word and drives the PWM's 4-bit duty input. Duty changes only on PWM period boundaries, so the PWM never sees a mid-period glitch. Soft-start and soft-stop use the same ramp, and a fault input forces duty to 0 immediately.

Parameters:
DUTY_W, 4, width of target and duty words
DUTY_MAX, 8, clamp value for duty; 8 means 100% for an 8-cycle period
PERIOD, 8, PWM period in clk cycles; must equal the PWM counter modulus
STEP_DIV, 4, number of PWM periods per ±1 duty step (≥1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
en  in  1  1 = ramp toward target; 0 = ramp down to 0, then idle
target  in  DUTY_W  requested duty; sampled every cycle
fault  in  1  level; forces FAULT state
fault_clr  in  1  single-cycle pulse; leaves FAULT if fault=0
duty  out  DUTY_W  registered duty word to the PWM
period_tick  out  1  high during the last cycle of each period (pcnt==PERIOD-1)
at_target  out  1  high when state==HOLD
state  out  2  IDLE=0, RAMP=1, HOLD=2, FAULT=3

Behaviour:
- Reset (rst_n=0 at a clk edge) clears pcnt, sdiv and duty to 0 and sets state=IDLE. Hence duty=0, state=0, at_target=0, period_tick=0 (pcnt=0 when PERIOD>1). Reset mid-ramp gives the same result.
- pcnt counts 0..PERIOD-1 and wraps. It runs free in every state, aligned with the PWM counter since both reset together.
- tgt_c = min(target, DUTY_MAX). eff_tgt = en ? tgt_c : 0.
- Duty updates only on a period_tick edge, so a new duty is visible at pcnt==0. The only exception is fault.
- IDLE: duty held at 0, sdiv=0. en=1 goes to RAMP next cycle.
- RAMP, on each period_tick:
  - if sdiv==STEP_DIV-1: duty moves ±1 toward eff_tgt and sdiv returns to 0;
  - otherwise sdiv++.
  - Direction is re-evaluated at every step, so a target change mid-ramp reverses or extends the ramp without restarting.
- RAMP exits (registered duty compared each cycle):
  - duty==eff_tgt and en=1 goes to HOLD;
  - duty==0 and en=0 goes to IDLE.
- HOLD exits:
  - duty!=eff_tgt goes to RAMP with sdiv cleared to 0;
  - en=0 with duty==0 goes to IDLE.
- HOLD, target==duty: no change.
- Latency: the first step lands on the STEP_DIV-th period_tick after entering RAMP. The first period may be partial.
- Full ramp 0→8 with default parameters takes at most 8·4·8 = 256 cycles plus one partial period.
- FAULT:
  - fault=1 in any state sets state=FAULT and duty=0 on the next edge, with no boundary wait; sdiv=0.
  - fault has priority over en, target and fault_clr.
  - Exit to IDLE only when fault_clr=1 and fault=0 in the same cycle. fault_clr while fault=1 is ignored.
  - fault_clr outside FAULT has no effect.
- Boundary conditions:
  - target>DUTY_MAX clamps, so target=15 ramps to 8.
  - target=0 with en=1: from IDLE go to RAMP, then to HOLD the next cycle at duty 0.
  - Duty never underflows below 0 or exceeds DUTY_MAX.
  - en toggling mid-step does not reset sdiv.
- Arithmetic is unsigned, DUTY_W bits. sdiv is wide enough for STEP_DIV-1 and pcnt for PERIOD-1.

Test Plan:
- Reset, then en=1, target=8 (defaults) → duty steps 0→1→…→8, changing only on the cycle after period_tick, with 32 cycles between steps. at_target=1 and state=2 after reaching 8.
- In HOLD at 8, set target=3 → state=1, duty steps down 8→3 at 32-cycle spacing, then state=2.
- target=15, en=1 → duty saturates at 8. at_target asserts and duty never shows 9..15.
- At duty=5, raise fault=1 between boundaries → duty=0 and state=3 on the next edge. fault_clr while fault=1 → stays 3. fault=0 with fault_clr pulse → state=0, then ramps again from 0.
- At duty=6, set en=0 → ramps 6→0 in 32-cycle steps, then state=0. Reassert rst_n=0 mid-ramp → next edge duty=0 and state=0.
- Ramp 0→4, then at duty=2 change target to 1 → next step goes to 1, then HOLD. period_tick pulses exactly every 8 cycles throughout.
